// File: rtl/avg_pool_pkg.sv
// avg_pool_pkg: shared types and width helpers for the 2x2 average-pool
// sequencer. The address-width helpers are also meant for the feature-map
// buffers, so both sides of the read/write ports agree on RA_W / WA_W.
package avg_pool_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} avg_pool_state_t;

  // Counter width for values 0..n-1, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int rd_addr_w(input int fmaps, input int in_dim);
    return $clog2(fmaps * in_dim * in_dim);
  endfunction

  function automatic int wr_addr_w(input int fmaps, input int in_dim);
    return $clog2(fmaps * (in_dim / 2) * (in_dim / 2));
  endfunction

endpackage

// File: rtl/avg_pool_addr_gen.sv
// avg_pool_addr_gen: nested window counters (k innermost, then c, r, m).
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   advance   - step the counters by one read
//   k         - pixel index within the current window (0..3)
//   last      - current read is the final read of the pass
//   rd_addr   - read address of the current counters (combinational)
//   wa_d      - output-buffer address of the window read one cycle ago
module avg_pool_addr_gen
  import avg_pool_pkg::*;
#(
  parameter  int FMAPS  = 3,
  parameter  int IN_DIM = 10,
  localparam int RA_W   = rd_addr_w(FMAPS, IN_DIM),
  localparam int WA_W   = wr_addr_w(FMAPS, IN_DIM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  output logic [1:0]      k,
  output logic            last,
  output logic [RA_W-1:0] rd_addr,
  output logic [WA_W-1:0] wa_d
);

  localparam int OD = IN_DIM / 2;
  localparam int MW = cnt_w(FMAPS);
  localparam int OW = cnt_w(OD);

  logic [MW-1:0] m;
  logic [OW-1:0] r, c;
  logic          c_last, r_last, m_last;

  assign c_last = (c == OW'(OD - 1));
  assign r_last = (r == OW'(OD - 1));
  assign m_last = (m == MW'(FMAPS - 1));
  assign last   = (k == 2'd3) && c_last && r_last && m_last;

  // k[1] selects the lower row of the window, k[0] the right column.
  assign rd_addr = RA_W'(int'(m) * IN_DIM * IN_DIM
                       + (2 * int'(r) + int'(k[1])) * IN_DIM
                       + 2 * int'(c) + int'(k[0]));

  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0;
      c <= '0;
      r <= '0;
      m <= '0;
    end else if (advance) begin
      k <= k + 2'd1;
      if (k == 2'd3) begin
        c <= c_last ? '0 : c + 1'b1;
        if (c_last) begin
          r <= r_last ? '0 : r + 1'b1;
          if (r_last) m <= m_last ? '0 : m + 1'b1;
        end
      end
    end
  end

  // One-cycle delayed window address, aligned with the returning read data.
  always_ff @(posedge clk) begin
    if (rst) wa_d <= '0;
    else     wa_d <= WA_W'(int'(m) * OD * OD + int'(r) * OD + int'(c));
  end

endmodule

// File: rtl/avg_pool_ctrl.sv
// avg_pool_ctrl: start/busy/done sequencer driving one 2x2 average-pool
// datapath over every window of every feature map.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - begin a pass (only looked at in IDLE)
//   busy, done        - pass in progress / one-cycle completion pulse
//   rd_en, rd_addr    - input-buffer read port; rd_data returns 1 cycle later
//   wr_en, wr_addr,
//   wr_data           - output-buffer write port (registered)
module avg_pool_ctrl
  import avg_pool_pkg::*;
#(
  parameter  int FMAPS  = 3,
  parameter  int IN_DIM = 10,
  parameter  int DATA_W = 32,
  localparam int RA_W   = rd_addr_w(FMAPS, IN_DIM),
  localparam int WA_W   = wr_addr_w(FMAPS, IN_DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [RA_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [WA_W-1:0]   wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  generate
    if (IN_DIM % 2 != 0) begin : g_bad_dim
      $error("avg_pool_ctrl: IN_DIM must be even");
    end
  endgenerate

  localparam int AW = DATA_W + 2;

  avg_pool_state_t state, nxt;
  logic            last;
  logic [1:0]      k, k_d;
  logic            rd_vld_d;
  logic [WA_W-1:0] wa_d;

  avg_pool_addr_gen #(.FMAPS(FMAPS), .IN_DIM(IN_DIM)) u_addr (
    .clk     (clk),
    .rst     (rst),
    .advance (rd_en),
    .k       (k),
    .last    (last),
    .rd_addr (rd_addr),
    .wa_d    (wa_d)
  );

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last)  nxt = DRAIN;
      // The only write that can appear in DRAIN is the final one.
      DRAIN:   if (wr_en) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == RUN) || (state == DRAIN);
    done  = (state == DONE);
    rd_en = (state == RUN);
  end

  // ---- Datapath ----
  logic signed [AW-1:0] acc, din, sum;

  assign din = {{2{rd_data[DATA_W-1]}}, rd_data};
  assign sum = (k_d == 2'd0) ? din : acc + din;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_d <= 1'b0;
      k_d      <= '0;
    end else begin
      rd_vld_d <= rd_en;
      k_d      <= k;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (rd_vld_d) begin
        acc <= sum;
        if (k_d == 2'd3) begin
          wr_en   <= 1'b1;
          wr_addr <= wa_d;
          // Arithmetic shift floors negative averages; the sum of four
          // DATA_W values always fits back into DATA_W after /4.
          wr_data <= DATA_W'(sum >>> 2);
        end
      end
    end
  end

endmodule
